wb_ram_arbiter: RTL

- Two-master to one-slave Wishbone (pipelined) arbiter that shares the single-port block RAM between the instruction-fetch port (A) and the load/store port (B).
- Sits between the CPU fetch and memory units and the RAM slave.
- Owns grant sequencing, outstanding-transaction tracking, ack/data routing and bus abort.

---
 rtl/wb_ram_arbiter_pkg.sv | 19 +
 rtl/wb_ram_arbiter_if.sv | 23 ++
 rtl/wb_ram_arbiter_grant.sv | 70 +++++++
 rtl/wb_ram_arbiter.sv | 109 ++++++++++
 4 files changed

// File: rtl/wb_ram_arbiter_pkg.sv
// Shared types and width defaults for the two-master block RAM arbiter.
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } arb_state_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } arb_port_t;

  localparam int WB_AW     = 32;
  localparam int WB_DW     = 32;
  localparam int WB_LGPEND = 2;

endpackage

// File: rtl/wb_ram_arbiter_if.sv
// Pipelined Wishbone bundle. The master modport is the side that issues
// strobes; the slave modport is the side that stalls and acks.
interface wb_ram_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  localparam int SW = DW / 8;

  logic          cyc;
  logic          stb;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [SW-1:0] sel;
  logic          stall;
  logic          ack;
  logic [DW-1:0] rdata;

  modport master (output cyc, stb, we, addr, wdata, sel,
                  input  stall, ack, rdata);
  modport slave  (input  cyc, stb, we, addr, wdata, sel,
                  output stall, ack, rdata);
endinterface

// File: rtl/wb_ram_arbiter_grant.sv
// Grant FSM for the RAM arbiter. Tie-break is fixed (B wins) unless
// ARB_ROUND_ROBIN_EN is defined, in which case the tie goes to the port
// that was not granted last.
//
//   state | meaning
//   IDLE  | nobody owns the RAM; one cycle between any two grants
//   OWN_A | fetch port A owns the RAM until it drops cyc
//   OWN_B | load/store port B owns the RAM until it drops cyc
module wb_arb_grant
  import wb_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_a_cyc,
  input  logic       i_b_cyc,
  output arb_state_t o_state,
  output arb_port_t  o_last
);

  arb_state_t state_q, state_d;
  arb_port_t  last_q, last_d;

  // Next grant and last-granted port
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (i_a_cyc && i_b_cyc) begin
`ifdef ARB_ROUND_ROBIN_EN
          if (last_q == PORT_B) begin
            state_d = OWN_A;
            last_d  = PORT_A;
          end else begin
            state_d = OWN_B;
            last_d  = PORT_B;
          end
`else
          state_d = OWN_B;
          last_d  = PORT_B;
`endif
        end else if (i_a_cyc) begin
          state_d = OWN_A;
          last_d  = PORT_A;
        end else if (i_b_cyc) begin
          state_d = OWN_B;
          last_d  = PORT_B;
        end
      end
      OWN_A:   if (!i_a_cyc) state_d = IDLE;
      OWN_B:   if (!i_b_cyc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant state registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      last_q  <= PORT_B;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  assign o_state = state_q;
  assign o_last  = last_q;

endmodule

// File: rtl/wb_ram_arbiter.sv
// Two-master to one-slave pipelined Wishbone arbiter in front of the
// single-port block RAM (A = instruction fetch, B = load/store).
// Optional round-robin tie-break: define ARB_ROUND_ROBIN_EN.
module wb_ram_arbiter
  import wb_pkg::*;
#(
  parameter int AW     = WB_AW,
  parameter int DW     = WB_DW,
  parameter int LGPEND = WB_LGPEND
) (
  input logic             i_clk,
  input logic             i_reset_n,
  wb_ram_arbiter_if.slave  a_bus,
  wb_ram_arbiter_if.slave  b_bus,
  wb_ram_arbiter_if.master s_bus
);

  localparam int SW = DW / 8;

  arb_state_t        state;
  arb_port_t         last;
  logic [LGPEND-1:0] pend_q, pend_d;
  logic              own_a, own_b, pend_full, release_bus;
  logic              cyc_m, stb_m, we_m, accept, ack_live, ack_route;
  logic [AW-1:0]     addr_m;
  logic [DW-1:0]     wdata_m;
  logic [SW-1:0]     sel_m;

  wb_arb_grant u_grant (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_a_cyc   (a_bus.cyc),
    .i_b_cyc   (b_bus.cyc),
    .o_state   (state),
    .o_last    (last)
  );

  assign own_a     = (state == OWN_A);
  assign own_b     = (state == OWN_B);
  assign pend_full = (pend_q == {LGPEND{1'b1}});

  // Owner's request onto the slave; strobe is held back at the pending
  // limit so the RAM never sees a strobe the master believes was stalled.
  always_comb begin
    cyc_m       = 1'b0;
    stb_m       = 1'b0;
    we_m        = 1'b0;
    addr_m      = '0;
    wdata_m     = '0;
    sel_m       = '0;
    a_bus.stall = 1'b1;
    b_bus.stall = 1'b1;
    if (own_a) begin
      cyc_m       = a_bus.cyc;
      stb_m       = a_bus.stb && !pend_full;
      we_m        = a_bus.we;
      addr_m      = a_bus.addr;
      wdata_m     = a_bus.wdata;
      sel_m       = a_bus.sel;
      a_bus.stall = s_bus.stall || pend_full;
    end else if (own_b) begin
      cyc_m       = b_bus.cyc;
      stb_m       = b_bus.stb && !pend_full;
      we_m        = b_bus.we;
      addr_m      = b_bus.addr;
      wdata_m     = b_bus.wdata;
      sel_m       = b_bus.sel;
      b_bus.stall = s_bus.stall || pend_full;
    end
  end

  assign s_bus.cyc   = cyc_m;
  assign s_bus.stb   = stb_m;
  assign s_bus.we    = we_m;
  assign s_bus.addr  = addr_m;
  assign s_bus.wdata = wdata_m;
  assign s_bus.sel   = sel_m;

  // Acks with nothing outstanding are leftovers from an aborted grant.
  assign ack_live  = s_bus.ack && (pend_q != '0);
  assign ack_route = ack_live && (own_a || own_b);
  assign accept    = stb_m && !s_bus.stall;

  assign a_bus.ack   = ack_live && own_a;
  assign b_bus.ack   = ack_live && own_b;
  assign a_bus.rdata = s_bus.rdata;
  assign b_bus.rdata = s_bus.rdata;

  assign release_bus = (state == IDLE) || (own_a && !a_bus.cyc) ||
                       (own_b && !b_bus.cyc);

  // Outstanding-request count; dropped on release so an abort starts clean
  always_comb begin
    pend_d = pend_q;
    if (release_bus)
      pend_d = '0;
    else if (accept && !ack_route)
      pend_d = pend_q + 1'b1;
    else if (ack_route && !accept)
      pend_d = pend_q - 1'b1;
  end

  // Pending counter register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) pend_q <= '0;
    else            pend_q <= pend_d;
  end

endmodule
